// File: rtl/apuf_pkg.sv
// Shared types, default timing and parameter checks for the arbiter-PUF
// evaluation sequencer.
package apuf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DISCHARGE = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_SAMPLE    = 3'd3,
        ST_RESULT    = 3'd4
    } state_t;

    localparam int NUM_EVAL_DEF      = 7;
    localparam int IDLE_CYCLES_DEF   = 4;
    localparam int SETTLE_CYCLES_DEF = 16;

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Odd vote count keeps the majority unambiguous; the settle minimum leaves
    // room for the two-flop synchroniser to catch up before sampling.
    function automatic bit params_ok(input int num_eval, input int idle_cycles,
                                     input int settle_cycles);
        return (num_eval >= 1) && (num_eval <= 255) && ((num_eval % 2) == 1) &&
               (idle_cycles >= 1) && (settle_cycles >= 3);
    endfunction

endpackage

// File: rtl/apuf_eval_sequencer_if.sv
// Command/result handshake and PUF drive bundle for the evaluation sequencer.
interface apuf_eval_sequencer_if #(
    parameter int C_LENGTH = 64,
    parameter int R_LENGTH = 64
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [C_LENGTH-1:0] cmd_challenge;
    logic                abort;
    logic                puf_ipulse;
    logic [C_LENGTH-1:0] puf_challenge;
    logic [R_LENGTH-1:0] puf_response;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [R_LENGTH-1:0] rsp_response;
    logic [R_LENGTH-1:0] rsp_stable;
    logic                rsp_unstable;
    logic                busy;

    // Register front end plus PUF core side.
    modport master (
        output cmd_valid, cmd_challenge, abort, rsp_ready, puf_response,
        input  cmd_ready, puf_ipulse, puf_challenge, rsp_valid,
               rsp_response, rsp_stable, rsp_unstable, busy
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_challenge, abort, rsp_ready, puf_response,
        output cmd_ready, puf_ipulse, puf_challenge, rsp_valid,
               rsp_response, rsp_stable, rsp_unstable, busy
    );
endinterface

// File: rtl/apuf_vote_accum.sv
// Per-bit ones counters for majority voting over repeated PUF evaluations.
// Majority/stability outputs reflect the counts as they will be after this
// cycle's clear/accumulate, so the caller can register the final verdict in
// the same cycle as the last sample.
module apuf_vote_accum
    import apuf_pkg::*;
#(
    parameter int R_LENGTH = 64,
    parameter int NUM_EVAL = NUM_EVAL_DEF
) (
    input  logic                i_clk,
    input  logic                i_srst,
    input  logic                i_clear,
    input  logic                i_accum,
    input  logic [R_LENGTH-1:0] i_bits,
    output logic [R_LENGTH-1:0] o_majority,
    output logic [R_LENGTH-1:0] o_stable
);
    localparam int CW = cnt_width(NUM_EVAL);

    genvar gi;
    generate
        for (gi = 0; gi < R_LENGTH; gi++) begin : g_bit
            logic [CW-1:0] r_ones;
            logic [CW-1:0] w_ones_next;

            // Next count: clear wins over accumulate.
            always_comb begin
                w_ones_next = r_ones;
                if (i_clear) begin
                    w_ones_next = '0;
                end else if (i_accum) begin
                    w_ones_next = r_ones + CW'(i_bits[gi]);
                end
            end

            // Counter register.
            always_ff @(posedge i_clk) begin
                if (i_srst) begin
                    r_ones <= '0;
                end else begin
                    r_ones <= w_ones_next;
                end
            end

            assign o_majority[gi] = (w_ones_next > CW'(NUM_EVAL / 2));
            assign o_stable[gi]   = (w_ones_next == '0) || (w_ones_next == CW'(NUM_EVAL));
        end
    endgenerate
endmodule

// File: rtl/apuf_eval_sequencer.sv
// Sequences NUM_EVAL discharge/fire/sample rounds of the arbiter PUF for one
// challenge and returns a majority-voted response with a stability mask.
module apuf_eval_sequencer
    import apuf_pkg::*;
#(
    parameter int C_LENGTH      = 64,
    parameter int R_LENGTH      = 64,
    parameter int NUM_EVAL      = NUM_EVAL_DEF,
    parameter int IDLE_CYCLES   = IDLE_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input logic                    S_AXI_ACLK,
    input logic                    S_AXI_ARESET,
    apuf_eval_sequencer_if.slave   bus
);
    localparam int EW   = cnt_width(NUM_EVAL);
    localparam int TMAX = (IDLE_CYCLES > SETTLE_CYCLES) ? IDLE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = cnt_width(TMAX);

    generate
        if (!params_ok(NUM_EVAL, IDLE_CYCLES, SETTLE_CYCLES)) begin : g_bad_params
            $error("apuf_eval_sequencer: illegal NUM_EVAL/IDLE_CYCLES/SETTLE_CYCLES");
        end
    endgenerate

    state_t              r_state, w_state_next;
    logic [TW-1:0]       r_tmr, w_tmr_next;
    logic [EW-1:0]       r_eval_cnt, w_eval_cnt_next;
    logic                r_ipulse;
    logic [C_LENGTH-1:0] r_challenge;
    logic [R_LENGTH-1:0] r_sync1, r_sync2;
    logic                r_rsp_valid, r_rsp_unstable;
    logic [R_LENGTH-1:0] r_rsp_response, r_rsp_stable;
    logic                w_clear, w_accum, w_accept;
    logic [R_LENGTH-1:0] w_majority, w_stable;

    // Next state, phase timer and evaluation counter; abort overrides all.
    always_comb begin
        w_state_next    = r_state;
        w_tmr_next      = r_tmr;
        w_eval_cnt_next = r_eval_cnt;
        w_clear         = 1'b0;
        w_accum         = 1'b0;
        w_accept        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid && !bus.abort) begin
                    w_accept        = 1'b1;
                    w_clear         = 1'b1;
                    w_eval_cnt_next = '0;
                    w_tmr_next      = TW'(IDLE_CYCLES - 1);
                    w_state_next    = ST_DISCHARGE;
                end
            end
            ST_DISCHARGE: begin
                if (r_tmr == '0) begin
                    w_tmr_next   = TW'(SETTLE_CYCLES - 1);
                    w_state_next = ST_SETTLE;
                end else begin
                    w_tmr_next = r_tmr - TW'(1);
                end
            end
            ST_SETTLE: begin
                if (r_tmr == '0) begin
                    w_state_next = ST_SAMPLE;
                end else begin
                    w_tmr_next = r_tmr - TW'(1);
                end
            end
            ST_SAMPLE: begin
                w_accum         = 1'b1;
                w_eval_cnt_next = r_eval_cnt + EW'(1);
                if (r_eval_cnt == EW'(NUM_EVAL - 1)) begin
                    w_state_next = ST_RESULT;
                end else begin
                    w_tmr_next   = TW'(IDLE_CYCLES - 1);
                    w_state_next = ST_DISCHARGE;
                end
            end
            ST_RESULT: begin
                if (bus.rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if ((r_state != ST_IDLE) && bus.abort) begin
            w_state_next    = ST_IDLE;
            w_clear         = 1'b1;
            w_accum         = 1'b0;
            w_eval_cnt_next = '0;
            w_tmr_next      = '0;
        end
    end

    // State, timer, counter and the registered PUF drive.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state     <= ST_IDLE;
            r_tmr       <= '0;
            r_eval_cnt  <= '0;
            r_ipulse    <= 1'b0;
            r_challenge <= '0;
        end else begin
            r_state    <= w_state_next;
            r_tmr      <= w_tmr_next;
            r_eval_cnt <= w_eval_cnt_next;
            r_ipulse   <= (w_state_next == ST_SETTLE) || (w_state_next == ST_SAMPLE);
            if (w_accept) begin
                r_challenge <= bus.cmd_challenge;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous PUF response.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.puf_response;
            r_sync2 <= r_sync1;
        end
    end

    // Result registers: loaded on the final sample, held through RESULT.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_response <= '0;
            r_rsp_stable   <= '0;
            r_rsp_unstable <= 1'b0;
        end else if ((r_state == ST_SAMPLE) && (w_state_next == ST_RESULT)) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_response <= w_majority;
            r_rsp_stable   <= w_stable;
            r_rsp_unstable <= ~&w_stable;
        end else if (w_state_next != ST_RESULT) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_response <= '0;
            r_rsp_stable   <= '0;
            r_rsp_unstable <= 1'b0;
        end
    end

    apuf_vote_accum #(
        .R_LENGTH (R_LENGTH),
        .NUM_EVAL (NUM_EVAL)
    ) u_vote (
        .i_clk      (S_AXI_ACLK),
        .i_srst     (S_AXI_ARESET),
        .i_clear    (w_clear),
        .i_accum    (w_accum),
        .i_bits     (r_sync2),
        .o_majority (w_majority),
        .o_stable   (w_stable)
    );

    assign bus.cmd_ready     = (r_state == ST_IDLE) && !bus.abort;
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.puf_ipulse    = r_ipulse;
    assign bus.puf_challenge = r_challenge;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_response  = r_rsp_response;
    assign bus.rsp_stable    = r_rsp_stable;
    assign bus.rsp_unstable  = r_rsp_unstable;
endmodule

// File: tb/tb_apuf_eval_sequencer.sv
// Randomised self-checking bench: two sequencer configurations, each checked
// every cycle against a timeline/vote model, plus literal expectations.
module tb_apuf_eval_sequencer;
    localparam int NE_A = 7, IC_A = 4, SC_A = 16;
    localparam int NE_B = 1, IC_B = 1, SC_B = 3;

    logic clk  = 1'b0;
    logic srst = 1'b1;
    int   cyc  = 0;
    int   checks = 0;
    int   failures = 0;
    int   acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apuf_eval_sequencer_if #(.C_LENGTH(64), .R_LENGTH(64)) if_a ();
    apuf_eval_sequencer_if #(.C_LENGTH(64), .R_LENGTH(64)) if_b ();

    apuf_eval_sequencer #(.C_LENGTH(64), .R_LENGTH(64), .NUM_EVAL(NE_A),
                          .IDLE_CYCLES(IC_A), .SETTLE_CYCLES(SC_A))
        dut_a (.S_AXI_ACLK(clk), .S_AXI_ARESET(srst), .bus(if_a));
    apuf_eval_sequencer #(.C_LENGTH(64), .R_LENGTH(64), .NUM_EVAL(NE_B),
                          .IDLE_CYCLES(IC_B), .SETTLE_CYCLES(SC_B))
        dut_b (.S_AXI_ACLK(clk), .S_AXI_ARESET(srst), .bus(if_b));

    int ne  [2] = '{NE_A, NE_B};
    int ic  [2] = '{IC_A, IC_B};
    int per [2] = '{IC_A + SC_A + 1, IC_B + SC_B + 1};

    // Model: mode 0 idle, 1 running (t = cycles since accept), 2 result held.
    int          m_mode [2];
    int          m_t    [2];
    bit          m_known[2];
    logic [63:0] m_chal [2];
    logic [63:0] m_resp [2];
    logic [63:0] m_stab [2];
    logic [63:0] h0 [2], h1 [2], h2 [2];
    int          m_ones [2][64];
    logic [63:0] plan   [2][8];

    function automatic logic rd_valid(input int d);  return d == 0 ? if_a.rsp_valid    : if_b.rsp_valid;    endfunction
    function automatic logic rd_ready(input int d);  return d == 0 ? if_a.cmd_ready    : if_b.cmd_ready;    endfunction
    function automatic logic rd_busy(input int d);   return d == 0 ? if_a.busy         : if_b.busy;         endfunction
    function automatic logic rd_ipulse(input int d); return d == 0 ? if_a.puf_ipulse   : if_b.puf_ipulse;   endfunction
    function automatic logic rd_unst(input int d);   return d == 0 ? if_a.rsp_unstable : if_b.rsp_unstable; endfunction
    function automatic logic [63:0] rd_chal(input int d); return d == 0 ? if_a.puf_challenge : if_b.puf_challenge; endfunction
    function automatic logic [63:0] rd_resp(input int d); return d == 0 ? if_a.rsp_response  : if_b.rsp_response;  endfunction
    function automatic logic [63:0] rd_stab(input int d); return d == 0 ? if_a.rsp_stable    : if_b.rsp_stable;    endfunction
    function automatic logic [63:0] rd_presp(input int d); return d == 0 ? if_a.puf_response : if_b.puf_response; endfunction
    function automatic logic [63:0] rd_cc(input int d);   return d == 0 ? if_a.cmd_challenge : if_b.cmd_challenge; endfunction
    function automatic logic rd_cv(input int d); return d == 0 ? if_a.cmd_valid : if_b.cmd_valid; endfunction
    function automatic logic rd_ab(input int d); return d == 0 ? if_a.abort     : if_b.abort;     endfunction
    function automatic logic rd_rr(input int d); return d == 0 ? if_a.rsp_ready : if_b.rsp_ready; endfunction

    task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL dut%0d %s actual=%h required=%h cyc=%0d", d, nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model, then advance the model with the
    // inputs that the coming rising edge will sample.
    logic        e_ip, e_val, e_rdy, e_busy;
    int          ph;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            h2[d] = h1[d];
            h1[d] = h0[d];
            h0[d] = rd_presp(d);
            if (m_known[d]) begin
                e_ip = 1'b0; e_val = 1'b0; e_rdy = 1'b0; e_busy = 1'b1;
                if (m_mode[d] == 0) begin
                    e_busy = 1'b0;
                    e_rdy  = !rd_ab(d);
                end else if (m_mode[d] == 1) begin
                    ph   = (m_t[d] - 1) % per[d];
                    e_ip = (ph >= ic[d]);
                end else begin
                    e_val = 1'b1;
                end
                chk(d, "puf_ipulse", 64'(rd_ipulse(d)), 64'(e_ip));
                chk(d, "rsp_valid",  64'(rd_valid(d)),  64'(e_val));
                chk(d, "cmd_ready",  64'(rd_ready(d)),  64'(e_rdy));
                chk(d, "busy",       64'(rd_busy(d)),   64'(e_busy));
                chk(d, "puf_challenge", rd_chal(d), m_chal[d]);
                chk(d, "valid_with_ready", 64'(rd_valid(d) & rd_ready(d)), 64'd0);
                if (m_mode[d] == 2) begin
                    chk(d, "rsp_response", rd_resp(d), m_resp[d]);
                    chk(d, "rsp_stable",   rd_stab(d), m_stab[d]);
                    chk(d, "rsp_unstable", 64'(rd_unst(d)), 64'(m_stab[d] != '1));
                end
            end
            if (srst) begin
                m_mode[d]  = 0;
                m_chal[d]  = '0;
                m_known[d] = 1'b1;
            end else if (m_known[d]) begin
                if (m_mode[d] == 0) begin
                    if (rd_cv(d) && !rd_ab(d)) begin
                        m_mode[d] = 1;
                        m_t[d]    = 1;
                        m_chal[d] = rd_cc(d);
                        for (int i = 0; i < 64; i++) m_ones[d][i] = 0;
                    end
                end else if (m_mode[d] == 1) begin
                    if (rd_ab(d)) begin
                        m_mode[d] = 0;
                    end else begin
                        if (((m_t[d] - 1) % per[d]) == per[d] - 1)
                            for (int i = 0; i < 64; i++) m_ones[d][i] += int'(h2[d][i]);
                        if (m_t[d] == ne[d] * per[d]) begin
                            m_mode[d] = 2;
                            for (int i = 0; i < 64; i++) begin
                                m_resp[d][i] = (m_ones[d][i] > ne[d] / 2);
                                m_stab[d][i] = (m_ones[d][i] == 0) || (m_ones[d][i] == ne[d]);
                            end
                        end else begin
                            m_t[d]++;
                        end
                    end
                end else begin
                    if (rd_ab(d) || rd_rr(d)) m_mode[d] = 0;
                end
            end
        end
    end

    // Stub PUF: presents the planned value for the evaluation in progress.
    int drv_k;
    initial begin
        #1;
        forever begin
            for (int d = 0; d < 2; d++) begin
                drv_k = (m_mode[d] == 1) ? (m_t[d] - 1) / per[d] : 0;
                if (d == 0) if_a.puf_response = plan[0][drv_k];
                else        if_b.puf_response = plan[1][drv_k];
            end
            @(posedge clk);
            #1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int d, input logic v, input logic [63:0] c);
        if (d == 0) begin if_a.cmd_valid = v; if_a.cmd_challenge = c; end
        else        begin if_b.cmd_valid = v; if_b.cmd_challenge = c; end
    endtask
    task automatic set_rdy(input int d, input logic v);
        if (d == 0) if_a.rsp_ready = v; else if_b.rsp_ready = v;
    endtask
    task automatic set_abort(input int d, input logic v);
        if (d == 0) if_a.abort = v; else if_b.abort = v;
    endtask

    task automatic send(input int d, input logic [63:0] c);
        bit got;
        got = 1'b0;
        tick();
        set_cmd(d, 1'b1, c);
        for (int n = 0; n < 600 && !got; n++) begin
            @(negedge clk);
            if (rd_ready(d)) begin got = 1'b1; acc_cyc = cyc; end
        end
        chk(d, "cmd_accepted", 64'(got), 64'd1);
        tick();
        set_cmd(d, 1'b0, '0);
    endtask

    task automatic wait_rsp(input int d, output int lat, output int hi);
        bit got;
        got = 1'b0; lat = -1; hi = 0;
        for (int n = 0; n < 2000 && !got; n++) begin
            @(negedge clk);
            if (rd_valid(d)) begin got = 1'b1; lat = cyc - acc_cyc; end
            else if (rd_ipulse(d)) hi++;
        end
        chk(d, "rsp_seen", 64'(got), 64'd1);
    endtask

    task automatic handshake(input int d, input int delay);
        repeat (delay) tick();
        set_rdy(d, 1'b1);
        tick();
        set_rdy(d, 1'b0);
    endtask

    task automatic wait_t(input int d, input int target);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 600 && !got; n++) begin
            @(negedge clk);
            #1;
            if (m_mode[d] == 1 && m_t[d] == target) got = 1'b1;
        end
        chk(d, "reached_t", 64'(got), 64'd1);
    endtask

    task automatic set_plan(input int d, input logic [63:0] v);
        for (int k = 0; k < 8; k++) plan[d][k] = v;
    endtask

    int          lat, hi;
    logic [63:0] cap_r, cap_s, base, c2;
    int          sel;

    initial begin
        set_cmd(0, 1'b0, '0); set_cmd(1, 1'b0, '0);
        set_rdy(0, 1'b0);     set_rdy(1, 1'b0);
        set_abort(0, 1'b0);   set_abort(1, 1'b0);
        set_plan(0, '0);      set_plan(1, '0);
        repeat (3) tick();
        srst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(d, "rst_valid",  64'(rd_valid(d)),  64'd0);
            chk(d, "rst_ipulse", 64'(rd_ipulse(d)), 64'd0);
            chk(d, "rst_chal",   rd_chal(d), 64'd0);
            chk(d, "rst_resp",   rd_resp(d), 64'd0);
            chk(d, "rst_ready",  64'(rd_ready(d)),  64'd1);
        end

        // Constant response, default timing.
        set_plan(0, 64'hDEAD_BEEF_0123_4567);
        send(0, 64'h0123_4567_89AB_CDEF);
        wait_rsp(0, lat, hi);
        chk(0, "latency", 64'(lat), 64'd148);
        chk(0, "ipulse_high_cycles", 64'(hi), 64'd119);
        chk(0, "const_resp", rd_resp(0), 64'hDEAD_BEEF_0123_4567);
        chk(0, "const_stable", rd_stab(0), 64'hFFFF_FFFF_FFFF_FFFF);
        chk(0, "const_unstable", 64'(rd_unst(0)), 64'd0);
        handshake(0, 0);

        // Bit 0 noisy: high on evaluations 1,3,5 then on 0,2,4,6.
        for (int k = 0; k < 7; k++) plan[0][k] = (k % 2 == 1) ? 64'h1 : 64'h0;
        send(0, 64'h55);
        wait_rsp(0, lat, hi);
        chk(0, "odd_resp", rd_resp(0), 64'h0);
        chk(0, "odd_stable", rd_stab(0), 64'hFFFF_FFFF_FFFF_FFFE);
        chk(0, "odd_unstable", 64'(rd_unst(0)), 64'd1);
        handshake(0, 1);
        for (int k = 0; k < 7; k++) plan[0][k] = (k % 2 == 0) ? 64'h1 : 64'h0;
        send(0, 64'hAA);
        wait_rsp(0, lat, hi);
        chk(0, "even_resp", rd_resp(0), 64'h1);
        chk(0, "even_stable", rd_stab(0), 64'hFFFF_FFFF_FFFF_FFFE);
        handshake(0, 2);

        // Backpressure with a pending command.
        base = {$urandom, $urandom};
        c2   = {$urandom, $urandom};
        set_plan(0, base);
        send(0, 64'h1234);
        wait_rsp(0, lat, hi);
        cap_r = rd_resp(0);
        cap_s = rd_stab(0);
        chk(0, "bp_resp", cap_r, base);
        tick();
        set_cmd(0, 1'b1, c2);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk(0, "bp_hold_valid", 64'(rd_valid(0)), 64'd1);
            chk(0, "bp_hold_resp",  rd_resp(0), cap_r);
            chk(0, "bp_hold_stab",  rd_stab(0), cap_s);
            chk(0, "bp_cmd_ready",  64'(rd_ready(0)), 64'd0);
        end
        tick();
        set_rdy(0, 1'b1);
        @(negedge clk);
        chk(0, "bp_no_early_accept", 64'(rd_ready(0)), 64'd0);
        tick();
        set_rdy(0, 1'b0);
        @(negedge clk);
        chk(0, "bp_ready_after_hs", 64'(rd_ready(0)), 64'd1);
        acc_cyc = cyc;
        tick();
        set_cmd(0, 1'b0, '0);
        @(negedge clk);
        chk(0, "bp_pending_busy", 64'(rd_busy(0)), 64'd1);
        chk(0, "bp_pending_chal", rd_chal(0), c2);
        wait_rsp(0, lat, hi);
        chk(0, "bp_latency", 64'(lat), 64'd148);
        handshake(0, 0);

        // Abort during SETTLE of evaluation 3, then counters must be fresh.
        set_plan(0, 64'hFFFF_0000_FFFF_0000);
        send(0, 64'h77);
        wait_t(0, 3 * per[0] + IC_A + 5);
        tick();
        set_abort(0, 1'b1);
        tick();
        set_abort(0, 1'b0);
        @(negedge clk);
        chk(0, "abort_ipulse", 64'(rd_ipulse(0)), 64'd0);
        chk(0, "abort_ready",  64'(rd_ready(0)),  64'd1);
        chk(0, "abort_valid",  64'(rd_valid(0)),  64'd0);
        set_plan(0, 64'h1);
        send(0, 64'h88);
        wait_rsp(0, lat, hi);
        chk(0, "post_abort_resp", rd_resp(0), 64'h1);
        chk(0, "post_abort_stable", rd_stab(0), 64'hFFFF_FFFF_FFFF_FFFF);
        handshake(0, 0);

        // Abort and command together in IDLE: nothing accepted.
        tick();
        set_abort(0, 1'b1);
        set_cmd(0, 1'b1, 64'h99);
        @(negedge clk);
        chk(0, "abort_cmd_ready", 64'(rd_ready(0)), 64'd0);
        tick();
        set_abort(0, 1'b0);
        set_cmd(0, 1'b0, '0);
        @(negedge clk);
        chk(0, "abort_cmd_busy", 64'(rd_busy(0)), 64'd0);

        // Reset in the middle of SETTLE.
        set_plan(0, 64'hCAFE);
        send(0, 64'h42);
        wait_t(0, 10);
        tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        @(negedge clk);
        chk(0, "midrst_busy",   64'(rd_busy(0)),   64'd0);
        chk(0, "midrst_ipulse", 64'(rd_ipulse(0)), 64'd0);
        chk(0, "midrst_valid",  64'(rd_valid(0)),  64'd0);
        chk(0, "midrst_chal",   rd_chal(0), 64'd0);
        chk(0, "midrst_ready",  64'(rd_ready(0)),  64'd1);
        send(0, 64'h43);
        wait_rsp(0, lat, hi);
        chk(0, "midrst_latency", 64'(lat), 64'd148);
        chk(0, "midrst_resp", rd_resp(0), 64'hCAFE);
        handshake(0, 0);

        // Randomised commands: sparse per-evaluation noise, random
        // backpressure and occasional aborts while running or in RESULT.
        for (int it = 0; it < 14; it++) begin
            base = {$urandom, $urandom};
            for (int k = 0; k < 7; k++)
                plan[0][k] = base ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            sel = $urandom_range(0, 3);
            send(0, {$urandom, $urandom});
            if (sel == 0) begin
                wait_t(0, $urandom_range(1, 146));
                tick();
                set_abort(0, 1'b1);
                tick();
                set_abort(0, 1'b0);
            end else begin
                wait_rsp(0, lat, hi);
                chk(0, "rand_latency", 64'(lat), 64'd148);
                if (sel == 1) begin
                    tick();
                    set_abort(0, 1'b1);
                    tick();
                    set_abort(0, 1'b0);
                    @(negedge clk);
                    chk(0, "result_abort_valid", 64'(rd_valid(0)), 64'd0);
                end else begin
                    handshake(0, $urandom_range(0, 5));
                end
            end
        end

        // Minimal configuration: one evaluation, shortest phases.
        base = {$urandom, $urandom};
        set_plan(1, base);
        send(1, 64'hB0B0);
        wait_rsp(1, lat, hi);
        chk(1, "min_latency", 64'(lat), 64'd6);
        chk(1, "min_resp", rd_resp(1), base);
        chk(1, "min_stable", rd_stab(1), 64'hFFFF_FFFF_FFFF_FFFF);
        handshake(1, 1);

        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
